env_st_rmw_sched: RTL and testbench

Read-modify-write scheduler for the envelope-generator state RAM. It is the client that drives that RAM's read and write ports. On each sweep request it reads every voice/envelope state word in address order and presents each to the envelope compute stage over a valid/ready handshake. It then writes the in-order updated words back to the same addresses. It sits between the sample-rate tick and the indexed envelope datapath.

---
 rtl/env_st_rmw_sched_pkg.sv | 23 ++
 rtl/env_st_rmw_sched_if.sv | 30 +++
 rtl/env_st_rmw_sched_st_skid2.sv | 66 ++++++
 rtl/env_st_rmw_sched.sv | 172 +++++++++++++++++
 tb/tb_env_st_rmw_sched.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/env_st_rmw_sched_pkg.sv
// Shared types and widths for the envelope-state read-modify-write scheduler.
// The state word is opaque here; only its width matters.
package env_sched_pkg;

    localparam int V_WIDTH         = 5;
    localparam int E_WIDTH         = 4;
    localparam int ADDR_W          = V_WIDTH + E_WIDTH;
    localparam int WIDTH_NUMERATOR = 37;
    localparam int WORD_W          = WIDTH_NUMERATOR + 16;
    localparam int OUT_W           = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } st_entry_t;

endpackage

// File: rtl/env_st_rmw_sched_if.sv
// RAM port and compute-stage handshake bundle; master is the scheduler side.
interface env_st_rmw_sched_if;
    import env_sched_pkg::*;

    logic              re;
    logic [ADDR_W-1:0] read_address;
    logic [WORD_W-1:0] memdata;
    logic              we;
    logic [ADDR_W-1:0] write_address;
    logic [WORD_W-1:0] data_out;
    logic              st_valid;
    logic              st_ready;
    logic [WORD_W-1:0] st_data;
    logic [ADDR_W-1:0] st_addr;
    logic              upd_valid;
    logic [WORD_W-1:0] upd_data;

    modport master (
        output re, read_address, we, write_address, data_out,
        output st_valid, st_data, st_addr,
        input  memdata, st_ready, upd_valid, upd_data
    );

    modport slave (
        input  re, read_address, we, write_address, data_out,
        input  st_valid, st_data, st_addr,
        output memdata, st_ready, upd_valid, upd_data
    );

endinterface

// File: rtl/env_st_rmw_sched_st_skid2.sv
// Two-entry FIFO with a registered head; carries {addr, data} toward compute.
module st_skid2
    import env_sched_pkg::*;
(
    input  logic      clk,
    input  logic      reset_reg_N,
    input  logic      push,
    input  st_entry_t din,
    input  logic      ready,
    output logic      valid,
    output st_entry_t head,
    output logic [1:0] occ
);

    st_entry_t  head_r;
    st_entry_t  tail_r;
    logic [1:0] cnt_r;
    logic [1:0] cnt_nxt_s;
    logic       valid_r;
    logic       pop_s;

    assign pop_s = valid_r && ready;
    assign valid = valid_r;
    assign head  = head_r;
    assign occ   = cnt_r;

    // Next occupancy; a push into a full FIFO without a pop is dropped.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({push, pop_s})
            2'b10:   cnt_nxt_s = (cnt_r == 2'd2) ? cnt_r : cnt_r + 2'd1;
            2'b01:   cnt_nxt_s = cnt_r - 2'd1;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Storage and head/valid registers.
    always_ff @(posedge clk) begin
        if (!reset_reg_N) begin
            head_r  <= '0;
            tail_r  <= '0;
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            valid_r <= (cnt_nxt_s != 2'd0);
            if (pop_s) begin
                if (cnt_r == 2'd2) begin
                    head_r <= tail_r;
                    if (push) begin
                        tail_r <= din;
                    end
                end else if (push) begin
                    head_r <= din;
                end
            end else if (push) begin
                if (cnt_r == 2'd0) begin
                    head_r <= din;
                end else if (cnt_r == 2'd1) begin
                    tail_r <= din;
                end
            end
        end
    end

endmodule

// File: rtl/env_st_rmw_sched.sv
// Sweeps the envelope state RAM in address order, hands each word to compute
// and writes the in-order updates back to the same addresses.
module env_st_rmw_sched
    import env_sched_pkg::*;
#(
    parameter int VOICES  = 32,
    parameter int V_OSC   = 8,
    parameter int O_ENVS  = 2,
    parameter int MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               reset_reg_N,
    input  logic               sweep_start,
    output logic               sweep_busy,
    output logic               sweep_done,
    output logic               err,
    env_st_rmw_sched_if.master bus
);

    localparam int V_ENVS = O_ENVS * V_OSC;
    localparam int N      = VOICES * V_ENVS;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] N_C   = CNT_W'(N);
    localparam logic [OUT_W-1:0] MAX_C = OUT_W'(MAX_OUT);

    sched_state_e      state_r;
    logic [CNT_W-1:0]  rd_cnt_r;
    logic [CNT_W-1:0]  wr_cnt_r;
    logic [OUT_W-1:0]  out_cnt_r;
    logic              pending_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              we_r;
    logic [ADDR_W-1:0] wa_r;
    logic [WORD_W-1:0] dout_r;
    logic              rd_pend_r;
    logic [ADDR_W-1:0] rd_addr_d_r;

    logic              re_s;
    logic              upd_ok_s;
    logic              st_pop_s;
    logic [1:0]        occ_s;
    logic [1:0]        occ_eff_s;
    logic              fifo_valid_s;
    st_entry_t         fifo_head_s;
    st_entry_t         fifo_din_s;

    assign fifo_din_s = '{addr: rd_addr_d_r, data: bus.memdata};

    st_skid2 u_skid (
        .clk         (clk),
        .reset_reg_N (reset_reg_N),
        .push        (rd_pend_r),
        .din         (fifo_din_s),
        .ready       (bus.st_ready),
        .valid       (fifo_valid_s),
        .head        (fifo_head_s),
        .occ         (occ_s)
    );

    assign st_pop_s          = fifo_valid_s && bus.st_ready;
    assign upd_ok_s          = bus.upd_valid && (out_cnt_r != {OUT_W{1'b0}});
    assign bus.re            = re_s;
    assign bus.read_address  = rd_cnt_r[ADDR_W-1:0];
    assign bus.we            = we_r;
    assign bus.write_address = wa_r;
    assign bus.data_out      = dout_r;
    assign bus.st_valid      = fifo_valid_s;
    assign bus.st_data       = fifo_head_s.data;
    assign bus.st_addr       = fifo_head_s.addr;
    assign sweep_busy        = busy_r;
    assign sweep_done        = done_r;
    assign err               = err_r;

    // Read issue: the word popped this cycle frees its slot, which keeps one word per cycle.
    always_comb begin
        occ_eff_s = occ_s;
        if (st_pop_s) begin
            occ_eff_s = occ_s - 2'd1;
        end else begin
            occ_eff_s = occ_s;
        end
        re_s = 1'b0;
        if ((state_r == RUN) && (rd_cnt_r < N_C) && (out_cnt_r < MAX_C) &&
            ((occ_eff_s + {1'b0, rd_pend_r}) < 2'd2)) begin
            re_s = 1'b1;
        end else begin
            re_s = 1'b0;
        end
    end

    // Sweep FSM, counters and registered RAM/status outputs.
    always_ff @(posedge clk) begin
        if (!reset_reg_N) begin
            state_r     <= IDLE;
            rd_cnt_r    <= '0;
            wr_cnt_r    <= '0;
            out_cnt_r   <= '0;
            pending_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            we_r        <= 1'b0;
            wa_r        <= '0;
            dout_r      <= '0;
            rd_pend_r   <= 1'b0;
            rd_addr_d_r <= '0;
        end else begin
            rd_pend_r   <= re_s;
            rd_addr_d_r <= rd_cnt_r[ADDR_W-1:0];
            case ({re_s, upd_ok_s})
                2'b10:   out_cnt_r <= out_cnt_r + 4'd1;
                2'b01:   out_cnt_r <= out_cnt_r - 4'd1;
                default: out_cnt_r <= out_cnt_r;
            endcase
            we_r <= upd_ok_s;
            if (upd_ok_s) begin
                wa_r   <= wr_cnt_r[ADDR_W-1:0];
                dout_r <= bus.upd_data;
            end
            if (bus.upd_valid && !upd_ok_s) begin
                err_r <= 1'b1;
            end
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A request merged while busy launches here, with busy held high.
                    if (sweep_start || pending_r) begin
                        state_r   <= RUN;
                        busy_r    <= 1'b1;
                        pending_r <= 1'b0;
                        rd_cnt_r  <= '0;
                        wr_cnt_r  <= '0;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (sweep_start) begin
                        pending_r <= 1'b1;
                    end
                    if (re_s) begin
                        rd_cnt_r <= rd_cnt_r + 10'd1;
                    end
                    if (upd_ok_s) begin
                        wr_cnt_r <= wr_cnt_r + 10'd1;
                    end
                    if (rd_cnt_r == N_C) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (sweep_start) begin
                        pending_r <= 1'b1;
                    end
                    if (upd_ok_s) begin
                        wr_cnt_r <= wr_cnt_r + 10'd1;
                    end
                    if (wr_cnt_r == N_C) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_env_st_rmw_sched.sv
// Scoreboard bench: sweeps push expected write-backs, a negedge monitor checks them.
module tb_env_st_rmw_sched;
    import env_sched_pkg::*;

    localparam int VOICES  = 4;
    localparam int V_OSC   = 2;
    localparam int O_ENVS  = 1;
    localparam int N       = VOICES * V_OSC * O_ENVS;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_reg_N;
    logic sweep_start;
    logic sweep_busy;
    logic sweep_done;
    logic err;

    env_st_rmw_sched_if bus ();

    env_st_rmw_sched #(
        .VOICES  (VOICES),
        .V_OSC   (V_OSC),
        .O_ENVS  (O_ENVS),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk         (clk),
        .reset_reg_N (reset_reg_N),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .err         (err),
        .bus         (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // RAM model with a one-cycle read latency and a bench preload port.
    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              preload_go = 1'b0;
    logic [WORD_W-1:0] preload_base = '0;
    always @(posedge clk) begin
        if (preload_go) begin
            for (int i = 0; i < N; i++) mem[i] <= preload_base + WORD_W'(i);
        end else if (bus.we) begin
            mem[bus.write_address] <= bus.data_out;
        end
        if (bus.re) bus.memdata <= mem[bus.read_address];
    end

    // Compute model: returns data+1 after lat cycles, strictly in order.
    typedef struct packed {
        logic [31:0]       due;
        logic [WORD_W-1:0] data;
    } job_t;
    job_t              jobs[$];
    int unsigned       cyc = 0;
    int                lat = 2;
    logic              mdl_upd = 1'b0;
    logic [WORD_W-1:0] mdl_data = '0;
    logic              spur_upd = 1'b0;
    assign bus.upd_valid = mdl_upd | spur_upd;
    assign bus.upd_data  = mdl_data;
    always @(posedge clk) begin
        job_t j;
        cyc <= cyc + 1;
        if (!reset_reg_N) begin
            jobs.delete();
            mdl_upd <= 1'b0;
        end else begin
            if (bus.st_valid && bus.st_ready) begin
                j.due  = cyc + 32'(lat);
                j.data = bus.st_data + 53'd1;
                jobs.push_back(j);
            end
            if (jobs.size() > 0 && jobs[0].due <= cyc) begin
                mdl_upd  <= 1'b1;
                mdl_data <= jobs[0].data;
                void'(jobs.pop_front());
            end else begin
                mdl_upd <= 1'b0;
            end
        end
    end

    logic rnd_ready = 1'b0;
    always @(posedge clk) begin
        #1 bus.st_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard monitor, sampling on the falling edge.
    st_entry_t exp_q[$];
    int   out_m = 0;
    int   max_seen = 0;
    int   reads_seen = 0;
    int   acc_seen = 0;
    int   dones = 0;
    logic chk_resume = 1'b0;
    logic prev_resume = 1'b0;
    always @(negedge clk) begin
        st_entry_t e;
        if (!reset_reg_N) begin
            out_m = 0; acc_seen = 0; prev_resume = 1'b0;
            exp_q.delete();
        end else begin
            if (chk_resume && prev_resume) check("resume_re", 64'(bus.re), 64'd1);
            if (bus.re) begin
                check("rd_addr", 64'(bus.read_address), 64'(reads_seen % N));
                check("out_limit", 64'(out_m < MAX_OUT), 64'd1);
                reads_seen++;
            end
            prev_resume = bus.upd_valid && (out_m == MAX_OUT) && ((reads_seen % N) != 0);
            out_m = out_m + (bus.re ? 1 : 0) - ((bus.upd_valid && out_m > 0) ? 1 : 0);
            if (out_m > max_seen) max_seen = out_m;
            if (bus.st_valid && bus.st_ready) begin
                check("st_addr", 64'(bus.st_addr), 64'(acc_seen % N));
                acc_seen++;
            end
            if (bus.we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 64'(bus.write_address), 64'h1ff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.write_address), 64'(e.addr));
                    check("wr_data", 64'(bus.data_out), 64'(e.data));
                end
            end
            if (sweep_done) begin
                dones++;
                check("done_busy", 64'(sweep_busy), 64'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
    endtask

    task automatic preload(input logic [WORD_W-1:0] base);
        preload_base = base;
        preload_go   = 1'b1;
        tick();
        preload_go   = 1'b0;
    endtask

    // Expected write-backs of sweep k over RAM preloaded with base+i.
    task automatic push_sweep(input logic [WORD_W-1:0] base, input int k);
        st_entry_t e;
        for (int i = 0; i < N; i++) begin
            e.addr = ADDR_W'(i);
            e.data = base + WORD_W'(i) + WORD_W'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sweep_busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("sweep_idle", 64'(sweep_busy), 64'd0);
        check("exp_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_vals();
        check("rst_busy", 64'(sweep_busy), 64'd0);
        check("rst_done", 64'(sweep_done), 64'd0);
        check("rst_re", 64'(bus.re), 64'd0);
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_raddr", 64'(bus.read_address), 64'd0);
        check("rst_waddr", 64'(bus.write_address), 64'd0);
        check("rst_dout", 64'(bus.data_out), 64'd0);
        check("rst_st_valid", 64'(bus.st_valid), 64'd0);
        check("rst_st_data", 64'(bus.st_data), 64'd0);
        check("rst_st_addr", 64'(bus.st_addr), 64'd0);
        check("rst_err", 64'(err), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int r0;
        int n;
        reset_reg_N = 1'b0;
        sweep_start = 1'b0;
        repeat (3) tick();
        chk_reset_vals();
        reset_reg_N = 1'b1;
        tick();

        // Basic sweep with latency probes on the first word.
        d0 = dones;
        preload(53'h15_A5A5_0000_0100);
        push_sweep(53'h15_A5A5_0000_0100, 1);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        check("lat_re", 64'(bus.re), 64'd1);
        check("lat_raddr", 64'(bus.read_address), 64'd0);
        check("lat_busy", 64'(sweep_busy), 64'd1);
        tick();
        check("lat_st_early", 64'(bus.st_valid), 64'd0);
        tick();
        check("lat_st_valid", 64'(bus.st_valid), 64'd1);
        check("lat_st_addr", 64'(bus.st_addr), 64'd0);
        check("lat_st_data", 64'(bus.st_data), 64'(53'h15_A5A5_0000_0100));
        wait_idle(200);
        check("sweep1_dones", 64'(dones - d0), 64'd1);
        check("no_err", 64'(err), 64'd0);

        // Random compute back-pressure.
        rnd_ready = 1'b1;
        preload(53'h00_0000_1234_0000);
        push_sweep(53'h00_0000_1234_0000, 1);
        pulse_start();
        wait_idle(500);
        rnd_ready = 1'b0;

        // Long compute latency: reads stall at MAX_OUT outstanding.
        lat = 10;
        max_seen = 0;
        chk_resume = 1'b1;
        preload(53'h1F_0000_0000_0040);
        push_sweep(53'h1F_0000_0000_0040, 1);
        pulse_start();
        wait_idle(500);
        chk_resume = 1'b0;
        check("max_outstanding", 64'(max_seen), 64'(MAX_OUT));

        // Three requests during one sweep merge into one extra sweep.
        lat = 2;
        d0 = dones;
        preload(53'h0A_0000_0000_0200);
        push_sweep(53'h0A_0000_0000_0200, 1);
        push_sweep(53'h0A_0000_0000_0200, 2);
        pulse_start();
        tick(); pulse_start();
        tick(); pulse_start();
        tick(); pulse_start();
        wait_idle(500);
        repeat (30) tick();
        check("pending_dones", 64'(dones - d0), 64'd2);
        check("pending_idle", 64'(sweep_busy), 64'd0);

        // Spurious update while idle.
        check("pre_spur_err", 64'(err), 64'd0);
        spur_upd = 1'b1;
        tick();
        spur_upd = 1'b0;
        check("spur_no_we", 64'(bus.we), 64'd0);
        check("spur_err", 64'(err), 64'd1);
        repeat (5) tick();
        check("spur_err_sticky", 64'(err), 64'd1);

        // Reset while draining, then a clean sweep.
        lat = 10;
        r0 = reads_seen;
        preload(53'h03_0000_0000_0000);
        push_sweep(53'h03_0000_0000_0000, 1);
        pulse_start();
        n = 0;
        while (reads_seen < r0 + N && n < 200) begin
            tick();
            n++;
        end
        check("drain_reached", 64'(reads_seen - r0), 64'(N));
        repeat (2) tick();
        reset_reg_N = 1'b0;
        tick();
        chk_reset_vals();
        reset_reg_N = 1'b1;
        tick();
        lat = 2;
        d0 = dones;
        preload(53'h07_0000_0000_0010);
        push_sweep(53'h07_0000_0000_0010, 1);
        pulse_start();
        wait_idle(200);
        check("post_rst_dones", 64'(dones - d0), 64'd1);
        check("post_rst_err", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
